// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and press-detect the pause and direction buttons.
// Latency: a raw level change is accepted at clk edge DEBOUNCE_CYCLES+2; pulse visible one cycle.
// Backpressure: none; enable low suppresses pulses and toggles while debouncing keeps running.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_pause,
  input  logic       btn_dir,
  output logic       pause,
  output logic       up_down,
  output logic       pause_pulse,
  output logic       dir_pulse,
  output logic [1:0] btn_state
);

  // Channel 0 is pause, channel 1 is direction; both are handled identically.
  localparam int NCH = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  // pause resets to 0 (running), up_down resets to 1 (count up).
  localparam logic [NCH-1:0] LEVEL_RST = 2'b10;

  // Bit 1 is the debounced level, bit 0 is "a count is in progress" (cnt != 0).
  typedef enum logic [1:0] {
    IDLE_LOW    = 2'b00,
    ARMING_HIGH = 2'b01,
    IDLE_HIGH   = 2'b10,
    ARMING_LOW  = 2'b11
  } state_e;

  logic [NCH-1:0]       btn_raw;
  logic [NCH-1:0]       s1_q, s1_d;
  logic [NCH-1:0]       s2_q, s2_d;
  logic [NCH-1:0]       pulse_q, pulse_d;
  logic [NCH-1:0]       level_q, level_d;
  logic [NCH-1:0]       stable;
  logic [CNT_WIDTH-1:0] cnt_q [NCH];
  logic [CNT_WIDTH-1:0] cnt_d [NCH];
  state_e               state_q [NCH];
  state_e               state_d [NCH];

  assign btn_raw = {btn_dir, btn_pause};

  // Next-state: synchroniser shift, debounce count, channel FSM and press detection.
  always_comb begin
    s1_d    = btn_raw;
    s2_d    = s1_q;
    pulse_d = '0;
    level_d = level_q;
    stable  = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]   = '0;
      state_d[i] = state_q[i];
      stable[i]  = (state_q[i] == IDLE_HIGH) || (state_q[i] == ARMING_LOW);
      if (s2_q[i] == stable[i]) begin
        // Input agrees with the accepted level: any partial count is discarded.
        state_d[i] = stable[i] ? IDLE_HIGH : IDLE_LOW;
      end else if (cnt_q[i] != CNT_LAST) begin
        cnt_d[i]   = cnt_q[i] + CNT_ONE;
        state_d[i] = stable[i] ? ARMING_LOW : ARMING_HIGH;
      end else begin
        // Count expired: accept the new level; only a rising acceptance is a press.
        state_d[i] = stable[i] ? IDLE_LOW : IDLE_HIGH;
        if (!stable[i] && enable) begin
          pulse_d[i] = 1'b1;
          level_d[i] = ~level_q[i];
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= '0;
      level_q <= LEVEL_RST;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= IDLE_LOW;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign pause       = level_q[0];
  assign up_down     = level_q[1];
  assign pause_pulse = pulse_q[0];
  assign dir_pulse   = pulse_q[1];
  assign btn_state   = stable;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_dir = 1'b0;
  logic       pause, up_down, pause_pulse, dir_pulse;
  logic [1:0] btn_state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btn_pause(btn_pause), .btn_dir(btn_dir),
    .pause(pause), .up_down(up_down),
    .pause_pulse(pause_pulse), .dir_pulse(dir_pulse),
    .btn_state(btn_state)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a channel accepts a new level once the last DC synchronised samples
  // all differ from the accepted level. Reset fills the history with the
  // reset level, so held buttons must be re-observed from scratch.
  bit m_valid = 1'b0;
  bit m_p1 [2], m_p2 [2];
  bit m_hist [2][DC];
  bit m_stable [2], m_level [2], m_pulse [2];
  bit m_btn [2];

  always @(posedge clk) begin
    m_btn[0] = btn_pause;
    m_btn[1] = btn_dir;
    m_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        m_p1[c] = 1'b0;
        m_p2[c] = 1'b0;
        m_stable[c] = 1'b0;
        m_level[c] = (c == 1);
        m_pulse[c] = 1'b0;
        for (int k = 0; k < DC; k++) m_hist[c][k] = 1'b0;
      end else begin
        bit all_diff;
        for (int k = DC - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = m_p2[c];
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++) if (m_hist[c][k] == m_stable[c]) all_diff = 1'b0;
        m_pulse[c] = 1'b0;
        if (all_diff) begin
          m_stable[c] = ~m_stable[c];
          if (m_stable[c] && enable) begin
            m_pulse[c] = 1'b1;
            m_level[c] = ~m_level[c];
          end
        end
        m_p2[c] = m_p1[c];
        m_p1[c] = m_btn[c];
      end
    end
  end

  // Every cycle, on the falling edge, the DUT must agree with the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model pause", 8'(pause), 8'(m_level[0]));
      check("model up_down", 8'(up_down), 8'(m_level[1]));
      check("model pause_pulse", 8'(pause_pulse), 8'(m_pulse[0]));
      check("model dir_pulse", 8'(dir_pulse), 8'(m_pulse[1]));
      check("model btn_state", 8'(btn_state), 8'({m_stable[1], m_stable[0]}));
    end
  end

  // Inputs set before step() are sampled by the edge it waits for; outputs are read 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_pause = 1'b0;
    btn_dir = 1'b0;
    enable = 1'b1;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    int pulses;

    // Reset held for three edges with random buttons.
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      btn_pause = 1'($urandom_range(0, 1));
      btn_dir = 1'($urandom_range(0, 1));
      step();
      check("reset pause", 8'(pause), 8'd0);
      check("reset up_down", 8'(up_down), 8'd1);
      check("reset pulses", 8'({dir_pulse, pause_pulse}), 8'd0);
      check("reset btn_state", 8'(btn_state), 8'd0);
    end
    do_reset();

    // Clean press: held for edges 1..20, released from edge 21.
    for (int k = 1; k <= 30; k++) begin
      btn_pause = (k <= 20);
      step();
      check("press pause_pulse", 8'(pause_pulse), 8'(k == 6));
      check("press pause", 8'(pause), 8'(k >= 6));
      check("press btn_state0", 8'(btn_state[0]), 8'((k >= 6) && (k < 26)));
    end

    // Bounce: 3 high, 1 low, 3 high, 1 low, then high from edge 9.
    do_reset();
    for (int k = 1; k <= 22; k++) begin
      btn_dir = (k != 4) && (k != 8) && (k <= 18);
      step();
      check("bounce dir_pulse", 8'(dir_pulse), 8'(k == 14));
      check("bounce up_down", 8'(up_down), 8'(k < 14));
    end

    // Simultaneous presses on both channels.
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      btn_pause = (k <= 10);
      btn_dir = (k <= 10);
      step();
      check("simul pause_pulse", 8'(pause_pulse), 8'(k == 6));
      check("simul dir_pulse", 8'(dir_pulse), 8'(k == 6));
    end
    check("simul pause", 8'(pause), 8'd1);
    check("simul up_down", 8'(up_down), 8'd0);

    // Enable low during acceptance: press is discarded, not queued.
    do_reset();
    enable = 1'b0;
    btn_pause = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      pulses += int'(pause_pulse);
    end
    check("en0 btn_state0", 8'(btn_state[0]), 8'd1);
    check("en0 pause", 8'(pause), 8'd0);
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      pulses += int'(pause_pulse);
    end
    check("en held pulses", 8'(pulses), 8'd0);
    btn_pause = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    check("en release btn_state0", 8'(btn_state[0]), 8'd0);
    btn_pause = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      pulses += int'(pause_pulse);
    end
    check("en repress pulses", 8'(pulses), 8'd1);
    check("en repress pause", 8'(pause), 8'd1);

    // Reset mid-debounce: reset low is sampled at edge 5, button held throughout.
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      btn_dir = 1'b1;
      reset = (k != 5);
      step();
      check("midrst dir_pulse", 8'(dir_pulse), 8'(k == 11));
      check("midrst up_down", 8'(up_down), 8'(k < 11));
      check("midrst btn_state1", 8'(btn_state[1]), 8'(k >= 11));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
